rggen_indirect_access_initiator: RTL

Register-bus initiator that performs indirect register accesses on behalf of a host. A single host command (index, read/write, data) is turned into an index-register write followed by a data-window access, with the response returned on a valid/ready channel. It drives the same register bus that `rggen_indirect_register` instances respond to, and is used by firmware-less controllers and bench drivers.

---
 rtl/rggen_indirect_access_initiator.sv | 99 +++++++++
 1 files changed

// File: rtl/rggen_indirect_access_initiator.sv
// rggen_indirect_access_initiator: turns host commands into index-write + data-window bus accesses
module rggen_indirect_access_initiator #(
  parameter int                         ADDRESS_WIDTH  = 16,
  parameter int                         DATA_WIDTH     = 32,
  parameter int                         INDEX_WIDTH    = 8,
  parameter logic [ADDRESS_WIDTH-1:0]   INDEX_ADDRESS  = '0,
  parameter logic [ADDRESS_WIDTH-1:0]   DATA_ADDRESS   = ADDRESS_WIDTH'(4),
  parameter int                         TIMEOUT_CYCLES = 255
)(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_req_write,
  input  logic [INDEX_WIDTH-1:0]   i_req_index,
  input  logic [DATA_WIDTH-1:0]    i_req_data,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [DATA_WIDTH-1:0]    o_rsp_data,
  output logic [1:0]               o_rsp_status,
  output logic                     o_bus_request,
  output logic [ADDRESS_WIDTH-1:0] o_bus_address,
  output logic                     o_bus_write,
  output logic [DATA_WIDTH-1:0]    o_bus_write_data,
  input  logic                     i_bus_done,
  input  logic [DATA_WIDTH-1:0]    i_bus_read_data,
  input  logic                     i_bus_error
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, INDEX, DATA, RESP} state_e;
  state_e                 r_state;
  state_e                 w_next;
  logic                   r_write;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_cache_valid;
  logic [INDEX_WIDTH-1:0] r_cache_index;
  logic [CW-1:0]          r_count;
  logic [DATA_WIDTH-1:0]  r_rsp_data;
  logic [1:0]             r_rsp_status;
  logic                   w_accept;
  logic                   w_hit;
  logic                   w_busy;
  logic                   w_timeout;
  assign w_accept  = r_state == IDLE && i_req_valid;
  assign w_hit     = r_cache_valid && r_cache_index == i_req_index;
  assign w_busy    = r_state == INDEX || r_state == DATA;
  // done on the last permitted cycle takes priority over the timeout
  assign w_timeout = TIMEOUT_CYCLES != 0 && w_busy && !i_bus_done && r_count == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_req_valid ? (w_hit ? DATA : INDEX) : IDLE;
      INDEX:   w_next = i_bus_done ? (i_bus_error ? RESP : DATA) : (w_timeout ? RESP : INDEX);
      DATA:    w_next = (i_bus_done || w_timeout) ? RESP : DATA;
      default: w_next = i_rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_write       <= 1'b0;
      r_index       <= '0;
      r_data        <= '0;
      r_cache_valid <= 1'b0;
      r_cache_index <= '0;
      r_count       <= '0;
      r_rsp_data    <= '0;
      r_rsp_status  <= 2'b00;
    end else begin
      if (w_accept) begin
        r_write <= i_req_write;
        r_index <= i_req_index;
        r_data  <= i_req_data;
      end
      r_count <= (w_next != r_state) ? '0 : (w_busy && !i_bus_done && r_count != '1) ? r_count + 1'b1 : r_count;
      if (r_state == INDEX && i_bus_done && !i_bus_error) begin
        r_cache_valid <= 1'b1;
        r_cache_index <= r_index;
      end
      if ((r_state == INDEX && i_bus_done && i_bus_error) || w_timeout) r_cache_valid <= 1'b0;
      if (w_busy && w_next == RESP) begin
        r_rsp_status <= w_timeout ? 2'b10 : i_bus_error ? 2'b01 : 2'b00;
        r_rsp_data   <= (r_state == DATA && i_bus_done && !i_bus_error && !r_write) ? i_bus_read_data : '0;
      end
    end
  end
  assign o_req_ready      = r_state == IDLE;
  assign o_rsp_valid      = r_state == RESP;
  assign o_rsp_data       = r_rsp_data;
  assign o_rsp_status     = r_rsp_status;
  assign o_bus_request    = w_busy;
  assign o_bus_address    = r_state == INDEX ? INDEX_ADDRESS : r_state == DATA ? DATA_ADDRESS : '0;
  assign o_bus_write      = r_state == INDEX || (r_state == DATA && r_write);
  assign o_bus_write_data = r_state == INDEX ? DATA_WIDTH'(r_index) : r_state == DATA ? r_data : '0;
endmodule
